// File: rtl/cnn_weight_bank_loader.sv
// Weight-port initiator: streams NBANK*2^(AW+3) words into the banked weight RAM,
// then optionally reads them back and compares the read sum against the write sum.
module cnn_weight_bank_loader #(
  parameter int AW     = 4,
  parameter int DW     = 24,
  parameter int NBANK  = 6,
  parameter int VERIFY = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          WIN_VALID,
  input  logic [DW-1:0] WIN_DATA,
  output logic          WIN_READY,
  output logic          W_WEN,
  output logic          W_REN,
  output logic [AW+5:0] W_ADDR,
  output logic [DW-1:0] W_WDATA,
  input  logic [DW-1:0] W_RDATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          CHK_OK,
  output logic          CHK_ERR
);

  localparam int CW     = AW + 6;
  localparam int SW     = DW + AW + 6;
  localparam int NWORDS = NBANK * (2 ** (AW + 3));
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);
  localparam logic [CW-1:0] N_IDX    = CW'(NWORDS);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [SW-1:0] wsum_r;
  logic [SW-1:0] rsum_r;
  logic [SW-1:0] rsum_next_s;
  logic          win_ready_r;
  logic          wen_r;
  logic          ren_r;
  logic          rdv_r;
  logic          busy_r;
  logic          done_r;
  logic          chk_ok_r;
  logic          chk_err_r;
  logic          hs_s;
  logic          last_hs_s;
  logic          rd_issue_s;

  // Handshake decode and read-sum accumulation term.
  always_comb begin
    hs_s        = 1'b0;
    last_hs_s   = 1'b0;
    rd_issue_s  = 1'b0;
    rsum_next_s = rsum_r;
    hs_s        = (state_r == ST_LOAD) && WIN_VALID && win_ready_r;
    last_hs_s   = hs_s && (cnt_r == LAST_IDX);
    rd_issue_s  = (state_r == ST_READ) && (cnt_r != N_IDX);
    if (rdv_r) begin
      rsum_next_s = rsum_r + SW'(W_RDATA);
    end else begin
      rsum_next_s = rsum_r;
    end
  end

  // Next-state logic; load-only builds still pass through DRAIN so DONE trails the last write by one cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) state_next_s = ST_LOAD;
        else       state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (last_hs_s) state_next_s = (VERIFY != 0) ? ST_READ : ST_DRAIN;
        else           state_next_s = ST_LOAD;
      end
      ST_READ: begin
        if (cnt_r == N_IDX) state_next_s = ST_DRAIN;
        else                state_next_s = ST_READ;
      end
      ST_DRAIN: state_next_s = ST_FIN;
      ST_FIN:   state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: counters, sums and every registered output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r       <= '0;
      addr_r      <= '0;
      wdata_r     <= '0;
      wsum_r      <= '0;
      rsum_r      <= '0;
      win_ready_r <= 1'b0;
      wen_r       <= 1'b0;
      ren_r       <= 1'b0;
      rdv_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      chk_ok_r    <= 1'b0;
      chk_err_r   <= 1'b0;
    end else begin
      win_ready_r <= (state_next_s == ST_LOAD);
      wen_r       <= 1'b0;
      ren_r       <= 1'b0;
      done_r      <= 1'b0;
      rdv_r       <= ren_r;
      rsum_r      <= rsum_next_s;
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            cnt_r     <= '0;
            wsum_r    <= '0;
            rsum_r    <= '0;
            chk_ok_r  <= 1'b0;
            chk_err_r <= 1'b0;
            busy_r    <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (hs_s) begin
            wen_r   <= 1'b1;
            addr_r  <= cnt_r;
            wdata_r <= WIN_DATA;
            wsum_r  <= wsum_r + SW'(WIN_DATA);
            cnt_r   <= last_hs_s ? '0 : cnt_r + ONE;
          end
        end
        ST_READ: begin
          if (rd_issue_s) begin
            ren_r  <= 1'b1;
            addr_r <= cnt_r;
            cnt_r  <= cnt_r + ONE;
          end
        end
        ST_DRAIN: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          if (VERIFY != 0) begin
            chk_ok_r  <= (rsum_next_s == wsum_r);
            chk_err_r <= (rsum_next_s != wsum_r);
          end else begin
            chk_ok_r  <= 1'b1;
            chk_err_r <= 1'b0;
          end
        end
        ST_FIN: begin
          done_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign WIN_READY = win_ready_r;
  assign W_WEN     = wen_r;
  assign W_REN     = ren_r;
  assign W_ADDR    = addr_r;
  assign W_WDATA   = wdata_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign CHK_OK    = chk_ok_r;
  assign CHK_ERR   = chk_err_r;

endmodule

// File: tb/tb_cnn_weight_bank_loader.sv
// Bench for cnn_weight_bank_loader: table of load scenarios on a 6-bank verify build
// and a 1-bank load-only build, with a write scoreboard and an ideal RAM model.
module tb_cnn_weight_bank_loader;

  localparam int AW  = 4;
  localparam int DW  = 24;
  localparam int ADW = AW + 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           start;
  logic           win_valid;
  logic [DW-1:0]  win_data;
  logic           sel_b;
  logic           corrupt;
  logic           start_a;
  logic           start_b;
  logic [DW-1:0]  rdata = '0;

  assign start_a = start & ~sel_b;
  assign start_b = start & sel_b;

  logic a_ready, a_wen, a_ren, a_busy, a_done, a_ok, a_err;
  logic [ADW-1:0] a_addr;
  logic [DW-1:0]  a_wdata;
  logic b_ready, b_wen, b_ren, b_busy, b_done, b_ok, b_err;
  logic [ADW-1:0] b_addr;
  logic [DW-1:0]  b_wdata;

  cnn_weight_bank_loader #(.AW(AW), .DW(DW), .NBANK(6), .VERIFY(1)) dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .WIN_VALID(win_valid), .WIN_DATA(win_data),
    .WIN_READY(a_ready), .W_WEN(a_wen), .W_REN(a_ren), .W_ADDR(a_addr), .W_WDATA(a_wdata),
    .W_RDATA(rdata), .BUSY(a_busy), .DONE(a_done), .CHK_OK(a_ok), .CHK_ERR(a_err)
  );

  cnn_weight_bank_loader #(.AW(AW), .DW(DW), .NBANK(1), .VERIFY(0)) dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .WIN_VALID(win_valid), .WIN_DATA(win_data),
    .WIN_READY(b_ready), .W_WEN(b_wen), .W_REN(b_ren), .W_ADDR(b_addr), .W_WDATA(b_wdata),
    .W_RDATA(rdata), .BUSY(b_busy), .DONE(b_done), .CHK_OK(b_ok), .CHK_ERR(b_err)
  );

  logic m_ready, m_wen, m_ren, m_busy, m_done, m_ok, m_err;
  logic [ADW-1:0] m_addr;
  logic [DW-1:0]  m_wdata;

  always_comb begin
    if (sel_b) begin
      {m_ready, m_wen, m_ren, m_busy, m_done, m_ok, m_err} = {b_ready, b_wen, b_ren, b_busy, b_done, b_ok, b_err};
      m_addr  = b_addr;
      m_wdata = b_wdata;
    end else begin
      {m_ready, m_wen, m_ren, m_busy, m_done, m_ok, m_err} = {a_ready, a_wen, a_ren, a_busy, a_done, a_ok, a_err};
      m_addr  = a_addr;
      m_wdata = a_wdata;
    end
  end

  // Ideal weight RAM; optionally flips bit 0 of word 0x155 on read.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (m_wen) mem[m_addr] <= m_wdata;
    if (m_ren) rdata <= mem[m_addr] ^ ((corrupt && (m_addr == 10'h155)) ? 24'h000001 : 24'h000000);
  end

  typedef struct {
    int id;
    bit use_b;
    bit corrupt;
    int gap;
    int restart_at;
    int rst_at;
    int nwords;
    int exp_reads;
    int exp_done;
    bit exp_ok;
    bit exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input int id, input string what, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %0s: got 0x%0h, required 0x%0h", id, what, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    logic [ADW-1:0] qa[$];
    logic [DW-1:0]  qd[$];
    int n = 0;
    int nwr = 0;
    int nrd = 0;
    int ndone = 0;
    int done_c = -1;
    int budget;
    bit done_seen = 1'b0;
    bit stop = 1'b0;
    budget  = (v.exp_done > 0) ? v.exp_done + 20 : 4000;
    sel_b   = v.use_b;
    corrupt = v.corrupt;
    @(negedge clk);
    start     = 1'b1;
    win_valid = 1'b1;
    win_data  = '0;
    check(v.id, "ready_before_start", 64'(m_ready), 64'(0));
    for (int c = 1; c <= budget && !stop; c++) begin
      @(negedge clk);
      start = (c == v.restart_at);
      rst   = (c == v.rst_at);
      if (v.rst_at > 0 && c == v.rst_at + 1) begin
        check(v.id, "outputs_after_rst",
              64'({m_ready, m_wen, m_ren, m_busy, m_done, m_ok, m_err, m_addr, m_wdata}), 64'(0));
        stop = 1'b1;
      end else begin
        if (c == 1) begin
          check(v.id, "ready_c1", 64'(m_ready), 64'(1));
          check(v.id, "chk_cleared_c1", 64'({m_ok, m_err}), 64'(0));
        end
        check(v.id, "wen_ren_exclusive", 64'(m_wen & m_ren), 64'(0));
        if (m_wen) begin
          check(v.id, "wen_has_handshake", 64'(qa.size() > 0), 64'(1));
          if (qa.size() > 0) begin
            check(v.id, "w_addr", 64'(m_addr), 64'(qa.pop_front()));
            check(v.id, "w_wdata", 64'(m_wdata), 64'(qd.pop_front()));
          end
          nwr++;
        end
        if (m_ren) begin
          check(v.id, "r_addr", 64'(m_addr), 64'(nrd));
          nrd++;
        end
        if (m_done) begin
          ndone++;
          if (!done_seen) done_c = c;
          done_seen = 1'b1;
          check(v.id, "chk_ok_at_done", 64'(m_ok), 64'(v.exp_ok));
          check(v.id, "chk_err_at_done", 64'(m_err), 64'(v.exp_err));
          check(v.id, "busy_at_done", 64'(m_busy), 64'(0));
        end else if (done_seen) begin
          check(v.id, "chk_held", 64'({m_ok, m_err}), 64'({v.exp_ok, v.exp_err}));
          if (c >= done_c + 4) stop = 1'b1;
        end else begin
          check(v.id, "busy_during_load", 64'(m_busy), 64'(1));
        end
      end
      if (!stop) begin
        win_valid = !rst && ((c % (v.gap + 1)) == 0);
        win_data  = (n < v.nwords) ? DW'(n) : 24'hABCDEF;
        if (win_valid && m_ready) begin
          qa.push_back(ADW'(n));
          qd.push_back(win_data);
          n++;
        end
      end
    end
    win_valid = 1'b0;
    start     = 1'b0;
    rst       = 1'b0;
    if (v.rst_at > 0) begin
      check(v.id, "no_done_on_abort", 64'(ndone), 64'(0));
    end else begin
      check(v.id, "done_within_budget", 64'(done_seen), 64'(1));
      check(v.id, "done_cycle", 64'(done_c), 64'(v.exp_done));
      check(v.id, "done_count", 64'(ndone), 64'(1));
      check(v.id, "handshakes", 64'(n), 64'(v.nwords));
      check(v.id, "writes", 64'(nwr), 64'(v.nwords));
      check(v.id, "reads", 64'(nrd), 64'(v.exp_reads));
      check(v.id, "scoreboard_drained", 64'(qa.size()), 64'(0));
    end
  endtask

  initial begin
    vec_t vecs[5];
    vec_t abort_v;
    rst       = 1'b1;
    start     = 1'b0;
    win_valid = 1'b0;
    win_data  = '0;
    sel_b     = 1'b0;
    corrupt   = 1'b0;

    //           id use_b corrupt gap restart rst  nwords reads done  ok    err
    vecs[0] = '{0, 1'b0, 1'b0, 0, -1, -1, 768, 768, 1539, 1'b1, 1'b0};
    vecs[1] = '{1, 1'b0, 1'b1, 0, -1, -1, 768, 768, 1539, 1'b0, 1'b1};
    vecs[2] = '{2, 1'b0, 1'b0, 2, -1, -1, 768, 768, 3075, 1'b1, 1'b0};
    vecs[3] = '{3, 1'b0, 1'b0, 0, 50, -1, 768, 768, 1539, 1'b1, 1'b0};
    vecs[4] = '{4, 1'b1, 1'b0, 0, -1, -1, 128, 0,   130,  1'b1, 1'b0};
    abort_v = '{5, 1'b0, 1'b0, 0, -1, 300, 768, 0,  -1,   1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check(9, "reset_outputs_a", 64'({a_ready, a_wen, a_ren, a_busy, a_done, a_ok, a_err, a_addr, a_wdata}), 64'(0));
    check(9, "reset_outputs_b", 64'({b_ready, b_wen, b_ren, b_busy, b_done, b_ok, b_err, b_addr, b_wdata}), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run(vecs[i]);
      repeat (3) @(negedge clk);
    end

    // Reset in the middle of LOAD, confirm the block stays quiet, then reload from address 0.
    run(abort_v);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check(5, "quiet_after_abort", 64'({m_wen, m_ren, m_done, m_busy, m_ready}), 64'(0));
    end
    run(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
